// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the decode-stage immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5,
    FmtZ    = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Fetch-side and register-read-side handshake bundle of the immediate generator.
interface imm_gen_pipe_if import imm_pkg::*; #(
  parameter int unsigned XLEN = 32
) ();

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  imm_fmt_e         out_fmt;
  logic [XLEN-1:0]  out_pc;
  logic             out_illegal;

  // Environment side: drives instructions in and accepts results.
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_pc, out_illegal
  );

  // Block side.
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_pc, out_illegal
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate extraction: instruction word to {imm, fmt, illegal}.
module imm_decode import imm_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0]         opcode;
  logic signed [11:0] i_raw;
  logic signed [11:0] s_raw;
  logic signed [12:0] b_raw;
  logic signed [31:0] u_raw;
  logic signed [20:0] j_raw;

  assign opcode = instr[6:0];
  assign i_raw  = instr[31:20];
  assign s_raw  = {instr[31:25], instr[11:7]};
  assign b_raw  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_raw  = {instr[31:12], 12'b0};
  assign j_raw  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Opcodes all end in 2'b11, so compressed encodings fall through to default.
  always_comb begin
    imm     = '0;
    fmt     = FmtNone;
    illegal = 1'b0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        imm = XLEN'(i_raw);
        fmt = FmtI;
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          imm = XLEN'(i_raw);
          fmt = FmtI;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        imm = XLEN'(s_raw);
        fmt = FmtS;
      end
      OPC_BRANCH: begin
        imm = XLEN'(b_raw);
        fmt = FmtB;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm = XLEN'(u_raw);
        fmt = FmtU;
      end
      OPC_JAL: begin
        imm = XLEN'(j_raw);
        fmt = FmtJ;
      end
      OPC_SYSTEM: begin
        if (instr[14]) begin
          imm = XLEN'(instr[19:15]);
          fmt = FmtZ;
        end
      end
      OPC_OP, OPC_MISC_MEM: begin
      end
      OPC_OP_32: illegal = (XLEN != 64);
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready flow control and an optional skid entry.
module imm_gen_pipe import imm_pkg::*; #(
  parameter int unsigned XLEN = 32,
  parameter bit          SKID = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  entry_t          dec_entry;

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   in_fire, out_fire;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign dec_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, pc: bus.in_pc};

  assign bus.in_ready = SKID ? ~skid_valid_q : (bus.out_ready | ~main_valid_q);
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = main_valid_q & bus.out_ready;

  // Main only loads when it is empty or draining; skid catches the one in flight otherwise.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_fire) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d       = dec_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (SKID && in_fire) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_comb begin
    bus.out_valid   = main_valid_q;
    bus.out_imm     = main_q.imm;
    bus.out_fmt     = main_q.fmt;
    bus.out_pc      = main_q.pc;
    bus.out_illegal = main_q.illegal;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized and directed checks of imm_gen_pipe in three configurations against a queue model.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) if32 ();
  imm_gen_pipe_if #(.XLEN(64)) if64 ();
  imm_gen_pipe_if #(.XLEN(32)) if0 ();

  imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
  imm_gen_pipe #(.XLEN(64), .SKID(1'b1)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64.slave));
  imm_gen_pipe #(.XLEN(32), .SKID(1'b0)) dut0  (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  ent_t        q32[$], q64[$], q0[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc_no = 0;
  int          out_cyc[$];
  logic [63:0] out_pc[$];
  logic [6:0]  ops[13] = '{7'h13, 7'h03, 7'h67, 7'h1b, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f,
                           7'h73, 7'h33, 7'h3b, 7'h0f};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the field layouts, using signed integer arithmetic.
  function automatic void ref_dec(input logic [31:0] w, input int xlen, output logic [63:0] imm,
                                  output logic [2:0] fmt, output logic ill);
    longint v = 0;
    fmt = 3'd0;
    ill = 1'b0;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: begin v = longint'(w[31:20]); if (w[31]) v -= 4096; fmt = 3'd1; end
      7'h1b: begin
        if (xlen == 64) begin v = longint'(w[31:20]); if (w[31]) v -= 4096; fmt = 3'd1; end
        else ill = 1'b1;
      end
      7'h23: begin v = longint'({w[31:25], w[11:7]}); if (w[31]) v -= 4096; fmt = 3'd2; end
      7'h63: begin
        v = longint'({w[31], w[7], w[30:25], w[11:8]}) * 2;
        if (w[31]) v -= 8192;
        fmt = 3'd3;
      end
      7'h37, 7'h17: begin
        v = longint'(w[31:12]) * 4096;
        if (w[31]) v -= (longint'(1) << 32);
        fmt = 3'd4;
      end
      7'h6f: begin
        v = longint'({w[31], w[19:12], w[20], w[30:21]}) * 2;
        if (w[31]) v -= 2097152;
        fmt = 3'd5;
      end
      7'h73: if (w[14]) begin v = longint'(w[19:15]); fmt = 3'd6; end
      7'h33, 7'h0f: ;
      7'h3b: ill = (xlen != 64);
      default: ill = 1'b1;
    endcase
    imm = 64'(v);
  endfunction

  task automatic check_side(input string tag, input int xlen, input int qsize, input ent_t head,
                            input logic ov, input logic [63:0] oimm, input logic [2:0] ofmt,
                            input logic oill, input logic [63:0] opc);
    logic [63:0] e_imm, mask;
    logic [2:0]  e_fmt;
    logic        e_ill;
    check_eq({tag, ".out_valid"}, 64'(ov), 64'(qsize > 0));
    if (qsize > 0) begin
      ref_dec(head.instr, xlen, e_imm, e_fmt, e_ill);
      mask = (xlen == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
      check_eq({tag, ".imm"}, oimm, e_imm & mask);
      check_eq({tag, ".fmt"}, 64'(ofmt), 64'(e_fmt));
      check_eq({tag, ".illegal"}, 64'(oill), 64'(e_ill));
      check_eq({tag, ".pc"}, opc, head.pc & mask);
    end
  endtask

  function automatic ent_t head_of(input ent_t q[$]);
    ent_t h;
    h.instr = '0;
    h.pc    = '0;
    if (q.size() > 0) h = q[0];
    return h;
  endfunction

  // One clock: drive on negedge, check just after, update the model at posedge.
  task automatic cycle(input logic vin, input logic [31:0] w, input logic [63:0] pc,
                       input logic ordy, input logic fl, output logic acc);
    logic r32, r64, r0, o32, o64, o0;
    ent_t e;
    @(negedge clk);
    if32.in_valid = vin; if32.in_instr = w; if32.in_pc = pc[31:0];
    if32.out_ready = ordy; if32.flush = fl;
    if64.in_valid = vin; if64.in_instr = w; if64.in_pc = pc;
    if64.out_ready = ordy; if64.flush = fl;
    if0.in_valid = vin; if0.in_instr = w; if0.in_pc = pc[31:0];
    if0.out_ready = ordy; if0.flush = fl;
    #1;
    check_side("s1x32", 32, q32.size(), head_of(q32), if32.out_valid, 64'(if32.out_imm),
               if32.out_fmt, if32.out_illegal, 64'(if32.out_pc));
    check_side("s1x64", 64, q64.size(), head_of(q64), if64.out_valid, if64.out_imm,
               if64.out_fmt, if64.out_illegal, if64.out_pc);
    check_side("s0x32", 32, q0.size(), head_of(q0), if0.out_valid, 64'(if0.out_imm),
               if0.out_fmt, if0.out_illegal, 64'(if0.out_pc));
    r32 = q32.size() < 2;
    r64 = q64.size() < 2;
    r0  = (q0.size() == 0) || ordy;
    check_eq("s1x32.in_ready", 64'(if32.in_ready), 64'(r32));
    check_eq("s1x64.in_ready", 64'(if64.in_ready), 64'(r64));
    check_eq("s0x32.in_ready", 64'(if0.in_ready), 64'(r0));
    acc = vin && r32;
    if (if32.out_valid && ordy) begin
      out_cyc.push_back(cyc_no);
      out_pc.push_back(64'(if32.out_pc));
    end
    o32 = (q32.size() > 0) && ordy;
    o64 = (q64.size() > 0) && ordy;
    o0  = (q0.size() > 0) && ordy;
    e.instr = w;
    e.pc    = pc;
    @(posedge clk);
    cyc_no++;
    if (fl) begin
      q32.delete(); q64.delete(); q0.delete();
    end else begin
      if (o32) void'(q32.pop_front());
      if (o64) void'(q64.pop_front());
      if (o0)  void'(q0.pop_front());
      if (vin && r32) q32.push_back(e);
      if (vin && r64) q64.push_back(e);
      if (vin && r0)  q0.push_back(e);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".s1x32.out_valid"}, 64'(if32.out_valid), 64'd0);
    check_eq({tag, ".s1x32.imm"}, 64'(if32.out_imm), 64'd0);
    check_eq({tag, ".s1x32.fmt"}, 64'(if32.out_fmt), 64'd0);
    check_eq({tag, ".s1x32.pc"}, 64'(if32.out_pc), 64'd0);
    check_eq({tag, ".s1x32.illegal"}, 64'(if32.out_illegal), 64'd0);
    check_eq({tag, ".s1x64.out_valid"}, 64'(if64.out_valid), 64'd0);
    check_eq({tag, ".s1x64.imm"}, if64.out_imm, 64'd0);
    check_eq({tag, ".s0x32.out_valid"}, 64'(if0.out_valid), 64'd0);
    check_eq({tag, ".s1x32.in_ready"}, 64'(if32.in_ready), 64'd1);
    check_eq({tag, ".s0x32.in_ready"}, 64'(if0.in_ready), 64'd1);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    if32.in_valid = 1'b0; if64.in_valid = 1'b0; if0.in_valid = 1'b0;
    if32.flush = 1'b0; if64.flush = 1'b0; if0.flush = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("midrst");
    q32.delete(); q64.delete(); q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 12)]};
  endfunction

  initial begin
    logic acc;
    int   idx;
    {if32.in_valid, if32.in_instr, if32.in_pc, if32.out_ready, if32.flush} = '0;
    {if64.in_valid, if64.in_instr, if64.in_pc, if64.out_ready, if64.flush} = '0;
    {if0.in_valid, if0.in_instr, if0.in_pc, if0.out_ready, if0.flush} = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Directed decode values.
    cycle(1'b1, 32'hFFF00093, 64'h40, 1'b1, 1'b0, acc);
    #1;
    check_eq("addi.valid", 64'(if32.out_valid), 64'd1);
    check_eq("addi.imm", 64'(if32.out_imm), 64'hFFFF_FFFF);
    check_eq("addi.fmt", 64'(if32.out_fmt), 64'd1);
    check_eq("addi.illegal", 64'(if32.out_illegal), 64'd0);
    cycle(1'b1, 32'hFE000EE3, 64'h44, 1'b1, 1'b0, acc);
    #1;
    check_eq("beq.imm", 64'(if32.out_imm), 64'hFFFF_FFFC);
    check_eq("beq.fmt", 64'(if32.out_fmt), 64'd3);
    cycle(1'b1, 32'h0080006F, 64'h48, 1'b1, 1'b0, acc);
    #1;
    check_eq("jal.imm", 64'(if32.out_imm), 64'h8);
    check_eq("jal.fmt", 64'(if32.out_fmt), 64'd5);
    cycle(1'b1, 32'h800002B7, 64'h4C, 1'b1, 1'b0, acc);
    #1;
    check_eq("lui64.imm", if64.out_imm, 64'hFFFF_FFFF_8000_0000);
    check_eq("lui64.fmt", 64'(if64.out_fmt), 64'd4);
    cycle(1'b1, 32'h0010009B, 64'h50, 1'b1, 1'b0, acc);
    #1;
    check_eq("addiw64.imm", if64.out_imm, 64'd1);
    check_eq("addiw64.fmt", 64'(if64.out_fmt), 64'd1);
    check_eq("addiw64.illegal", 64'(if64.out_illegal), 64'd0);
    check_eq("addiw32.illegal", 64'(if32.out_illegal), 64'd1);
    cycle(1'b1, 32'h300FD073, 64'h54, 1'b1, 1'b0, acc);
    #1;
    check_eq("csrrwi.imm", 64'(if32.out_imm), 64'h1F);
    check_eq("csrrwi.fmt", 64'(if32.out_fmt), 64'd6);
    cycle(1'b1, 32'h00000000, 64'h58, 1'b1, 1'b0, acc);
    #1;
    check_eq("zero.illegal", 64'(if32.out_illegal), 64'd1);
    check_eq("zero.imm", 64'(if32.out_imm), 64'd0);
    check_eq("zero.fmt", 64'(if32.out_fmt), 64'd0);
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    // Back-to-back A..D with out_ready low in cycles 1..3.
    idx = 0;
    cyc_no = 0;
    out_cyc.delete();
    out_pc.delete();
    for (int c = 0; c < 12; c++) begin
      cycle(idx < 4, {12'(idx), 20'h00093}, 64'h100 + 64'(4 * idx), !(c >= 1 && c <= 3), 1'b0,
            acc);
      if (acc) idx++;
      if (c == 1) begin
        #1;
        check_eq("skid.in_ready_low", 64'(if32.in_ready), 64'd0);
      end
    end
    check_eq("skid.accepted", 64'(idx), 64'd4);
    check_eq("skid.out_count", 64'(out_pc.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < out_pc.size()) begin
        check_eq("skid.order", out_pc[i], 64'h100 + 64'(4 * i));
        check_eq("skid.no_gap", 64'(out_cyc[i]), 64'(4 + i));
      end
    end

    // Fill both entries, then flush with a valid input that must be dropped.
    cycle(1'b1, 32'h00100093, 64'h200, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h00200093, 64'h204, 1'b0, 1'b0, acc);
    #1;
    check_eq("flush.full", 64'(if32.in_ready), 64'd0);
    cycle(1'b1, 32'h00500093, 64'h208, 1'b0, 1'b1, acc);
    #1;
    check_eq("flush.out_valid", 64'(if32.out_valid), 64'd0);
    check_eq("flush.in_ready", 64'(if32.in_ready), 64'd1);
    check_eq("flush.out_valid64", 64'(if64.out_valid), 64'd0);
    out_pc.delete();
    repeat (3) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
    check_eq("flush.dropped", 64'(out_pc.size()), 64'd0);

    // Randomized traffic with occasional flush and asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) mid_reset();
      cycle($urandom_range(0, 3) != 0, rand_instr(), {$urandom, $urandom},
            $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, flow-controlled immediate generator for the decode stage. It covers the full RV32I/RV64I immediate set: I, S, B, U (LUI and AUIPC), J, JALR, OP-IMM-32 and CSR zimm. It sign-extends each immediate to XLEN and carries the PC and a format tag alongside it. A valid/ready handshake with an optional skid buffer sits between fetch and the register-read stage, so backpressure never drops or duplicates an instruction.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64. 64 also enables OP-IMM-32 (0011011).
- SKID, 1:
  - 1 = two-entry skid buffer; in_ready is a register output; full throughput.
  - 0 = single output register; in_ready = out_ready | ~out_valid.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block accepts this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  imm_fmt_e tag.
- out_pc  out  XLEN  PC passed through unchanged.
- out_illegal  out  1  opcode is not decodable.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_imm=0, out_fmt=NONE, out_pc=0, out_illegal=0.
  - Skid entry is empty; in_ready=1 once rst_n is released.
- Transfers: a transfer happens on in_valid&in_ready (input) or on out_valid&out_ready (output).
  - Latency is 1 cycle from input transfer to out_valid.
  - Outputs stay stable while out_valid & ~out_ready.
- Decode table (opcode = instr[6:0]; sign bit = instr[31]; extension is to XLEN):
  - 0010011, 0000011, 1100111: I-type = sext(instr[31:20]).
  - 0011011: I-type when XLEN=64; illegal when XLEN=32.
  - 0100011: S-type = sext({instr[31:25], instr[11:7]}).
  - 1100011: B-type = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 0110111, 0010111: U-type = sext({instr[31:12], 12'b0}). For XLEN=64 bits [63:32] copy bit 31.
  - 1101111: J-type = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 1110011 with funct3[2]=1: Z-type = zero-extended instr[19:15].
  - 1110011 with funct3[2]=0: fmt NONE, imm 0, legal.
  - 0110011, 0111011 (0111011 only when XLEN=64), 0001111: fmt NONE, imm 0, legal.
  - Any other opcode, or instr[1:0]!=2'b11: out_illegal=1, fmt NONE, imm 0.
- SKID=1 datapath:
  - Main register plus one skid register; in_ready = ~skid_valid (registered).
  - An input accepted while main is full and out_ready=0 goes to skid.
  - When main drains, skid moves into main in the same edge.
  - Order is strictly preserved.
- SKID=0: a single register; a simultaneous output transfer and input transfer load the new item the same edge.
- Flush:
  - Clears main and skid valids on the next edge; any in_valid that cycle is dropped.
  - in_ready=1 the following cycle.
  - Flush has priority over every transfer.
- Reset asserted mid-operation: all entries are discarded immediately; no partial output.

Decomposition:
- Package imm_pkg:
  - imm_fmt_e (3-bit): NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.
  - Opcode localparams: OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_OP_IMM_32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM, OPC_OP, OPC_OP_32, OPC_MISC_MEM.
- Sub-module imm_decode (parameter XLEN): purely combinational, instr → {imm, fmt, illegal}.
- imm_gen_pipe holds only the handshake, skid and flush logic.

Test Plan:
1. ADDI 0xFFF00093 with out_ready=1 → next cycle out_imm=0xFFFFFFFF, fmt=I, out_illegal=0.
2. BEQ x0,x0,-4 (0xFE000EE3) → out_imm=0xFFFFFFFC, fmt=B. JAL 0x0080006F → out_imm=0x00000008, fmt=J.
3. XLEN=64:
   - LUI 0x800002B7 → out_imm=0xFFFFFFFF80000000, fmt=U.
   - 0x0010009B (ADDIW) → out_imm=1, fmt=I.
   - The same word at XLEN=32 → out_illegal=1.
4. SKID=1, back-to-back A,B,C,D with out_ready low for cycles 2–4:
   - in_ready drops after B is held.
   - Output sequence is exactly A,B,C,D with no gaps once out_ready returns high.
   - No duplicates.
5. Both entries full, then flush=1 for one cycle with in_valid=1 → out_valid=0 on the next edge; the flushed-cycle instruction never appears; in_ready=1.
6. CSRRWI 0x300FD073 → out_imm=0x1F, fmt=Z. Word 0x00000000 → out_illegal=1, imm=0, fmt=NONE.
